// File: rtl/mm_buf_loader.sv
// Writer side of the matmul operand buffers: turns a valid/ready stream of operand
// words into sequential writes across the 16 A-lane RAMs or the single B RAM.
module mm_buf_loader #(
  parameter int DW      = 264,
  parameter int LANES   = 16,
  parameter int A_DEPTH = 128,
  parameter int B_DEPTH = 2048,
  parameter int LEN_W   = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_target,
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_valid,
  input  logic [DW-1:0]              i_data,
  output logic                       o_ready,
  output logic [LANES-1:0]           o_a_we,
  output logic [$clog2(A_DEPTH)-1:0] o_a_addr,
  output logic                       o_b_we,
  output logic [$clog2(B_DEPTH)-1:0] o_b_addr,
  output logic [DW-1:0]              o_wdata,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int LANE_W = $clog2(LANES);
  localparam int AA_W   = $clog2(A_DEPTH);
  localparam int BA_W   = $clog2(B_DEPTH);
  localparam int CNT_W  = LEN_W + 1;
  // A capacity (LANES*A_DEPTH) equals B_DEPTH, so one clamp serves both targets.
  localparam logic [CNT_W-1:0] CAP = CNT_W'(B_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   rem_q;
  logic               target_q;
  logic [LANES-1:0]   a_we_q;
  logic [AA_W-1:0]    a_addr_q;
  logic               b_we_q;
  logic [BA_W-1:0]    b_addr_q;
  logic [DW-1:0]      wdata_q;

  logic [CNT_W-1:0]   len_ext;
  logic [CNT_W-1:0]   len_d;
  logic [BA_W-1:0]    word_idx;
  logic [LANES-1:0]   lane_onehot;
  logic               unused_cnt_hi;

  assign len_ext     = {1'b0, i_len};
  assign len_d       = (len_ext > CAP) ? CAP : len_ext;
  assign word_idx    = cnt_q[BA_W-1:0];
  assign lane_onehot = {{(LANES-1){1'b0}}, 1'b1} << word_idx[LANE_W-1:0];
  // After clamping, cnt never reaches past B_DEPTH, so its top bits never address anything.
  assign unused_cnt_hi = ^cnt_q[CNT_W-1:BA_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      target_q <= 1'b0;
      a_we_q   <= '0;
      a_addr_q <= '0;
      b_we_q   <= 1'b0;
      b_addr_q <= '0;
      wdata_q  <= '0;
    end else begin
      // NOTE: strobes default low with non-blocking assigns; a later assign in the same block wins.
      a_we_q <= '0;
      b_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            target_q <= i_target;
            rem_q    <= len_d;
            cnt_q    <= '0;
            state_q  <= (len_d == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (i_valid) begin
            if (target_q) begin
              b_we_q   <= 1'b1;
              b_addr_q <= word_idx;
            end else begin
              a_we_q   <= lane_onehot;
              a_addr_q <= word_idx[BA_W-1:LANE_W];
            end
            wdata_q <= i_data;
            cnt_q   <= cnt_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state_q == LOAD);
  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_a_we   = a_we_q;
  assign o_a_addr = a_addr_q;
  assign o_b_we   = b_we_q;
  assign o_b_addr = b_addr_q;
  assign o_wdata  = wdata_q;

endmodule

// File: tb/tb_mm_buf_loader.sv
// Directed bench for mm_buf_loader: B/A loads, backpressure, zero length,
// clamping with an ignored restart, and reset in the middle of a load.
module tb_mm_buf_loader;

  localparam int DW    = 264;
  localparam int LANES = 16;
  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             target;
  logic [LEN_W-1:0] len;
  logic             valid;
  logic [DW-1:0]    data;
  logic             ready;
  logic [LANES-1:0] a_we;
  logic [6:0]       a_addr;
  logic             b_we;
  logic [10:0]      b_addr;
  logic [DW-1:0]    wdata;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  int          nstrobe, ndone, nbad, a_seen, idx;
  logic [10:0] last_addr;
  logic [15:0] exp_we;
  logic [5:0]  pat;

  always #5 clk = ~clk;

  mm_buf_loader dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_target (target),
    .i_len    (len),
    .i_valid  (valid),
    .i_data   (data),
    .o_ready  (ready),
    .o_a_we   (a_we),
    .o_a_addr (a_addr),
    .o_b_we   (b_we),
    .o_b_addr (b_addr),
    .o_wdata  (wdata),
    .o_busy   (busy),
    .o_done   (done)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic tgt, input logic [LEN_W-1:0] n);
    start  = 1'b1;
    target = tgt;
    len    = n;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = 1'b0; len = '0; valid = 1'b0; data = '0;
    tick(); tick();
    check("rst_ready", ready, 0);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_a_we",  a_we,  0);
    check("rst_b_we",  b_we,  0);
    check("rst_wdata", wdata, 0);
    rst = 1'b0;
    tick();

    // Test 1: B load of 4 words, continuous valid.
    valid = 1'b1;
    data  = DW'(8'hA0);
    start_load(1'b1, 12'd4);
    check("t1_ready_load", ready, 1);
    check("t1_no_early_we", b_we, 0);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      data = DW'(8'hA0 + i);
      tick();
      check("t1_b_we",   b_we,   1);
      check("t1_b_addr", b_addr, i);
      check("t1_wdata",  wdata,  DW'(8'hA0 + i));
      check("t1_a_we",   a_we,   0);
      check("t1_done",   done,   (i == 3));
      check("t1_ready",  ready,  (i < 3));
    end
    valid = 1'b0;
    tick();
    check("t1_idle_we",   b_we,   0);
    check("t1_idle_done", done,   0);
    check("t1_idle_busy", busy,   0);
    check("t1_hold_addr", b_addr, 3);
    check("t1_hold_data", wdata,  DW'(8'hA3));

    // Test 2: A load of 18 words, lane advances fastest.
    valid = 1'b1;
    start_load(1'b0, 12'd18);
    for (int i = 0; i < 18; i++) begin
      data = DW'(16'h0100 + i);
      tick();
      exp_we = 16'h0001 << (i % 16);
      check("t2_a_we",   a_we,   exp_we);
      check("t2_a_addr", a_addr, i / 16);
      check("t2_b_we",   b_we,   0);
      check("t2_wdata",  wdata,  DW'(16'h0100 + i));
      check("t2_done",   done,   (i == 17));
    end
    valid = 1'b0;
    tick();
    check("t2_idle_a_we", a_we, 0);
    check("t2_hold_addr", a_addr, 1);

    // Test 3: backpressure, valid pattern 1,0,0,1,0,1.
    pat = 6'b101001;
    idx = 0;
    start_load(1'b1, 12'd3);
    for (int k = 0; k < 6; k++) begin
      valid = pat[k];
      data  = DW'(16'h0300 + k);
      tick();
      check("t3_b_we", b_we, pat[k]);
      if (pat[k]) begin
        check("t3_b_addr", b_addr, idx);
        check("t3_wdata",  wdata,  DW'(16'h0300 + k));
        idx++;
      end
      check("t3_done",  done,  (k == 5));
      check("t3_ready", ready, (k < 5));
    end
    valid = 1'b0;
    tick();
    check("t3_idle_busy", busy, 0);

    // Test 4: zero length goes straight to DONE.
    valid = 1'b1;
    start_load(1'b0, 12'd0);
    check("t4_done",  done,  1);
    check("t4_ready", ready, 0);
    check("t4_busy",  busy,  1);
    check("t4_a_we",  a_we,  0);
    check("t4_b_we",  b_we,  0);
    tick();
    check("t4_done_clear", done,  0);
    check("t4_idle_busy",  busy,  0);
    check("t4_idle_ready", ready, 0);
    valid = 1'b0;

    // Test 5: oversize B load clamps to 2048 words; mid-load start is ignored.
    nstrobe = 0; ndone = 0; nbad = 0; a_seen = 0; last_addr = '0;
    valid = 1'b1;
    start_load(1'b1, 12'd4000);
    for (int cyc = 0; cyc < 2100; cyc++) begin
      data = DW'(cyc);
      if (cyc == 100) begin
        start = 1'b1; target = 1'b0; len = 12'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      if (b_we) begin
        if (b_addr != 11'(nstrobe) || wdata[15:0] != 16'(nstrobe)) nbad++;
        last_addr = b_addr;
        nstrobe++;
      end
      if (done) ndone++;
      if (a_we != '0) a_seen++;
    end
    valid = 1'b0;
    check("t5_strobes",   nstrobe,   2048);
    check("t5_last_addr", last_addr, 2047);
    check("t5_seq_bad",   nbad,      0);
    check("t5_done_cnt",  ndone,     1);
    check("t5_a_we_seen", a_seen,    0);
    check("t5_last_data", wdata,     DW'(2047));
    check("t5_idle_busy", busy,      0);

    // Test 6: reset after 5 of 10 B words accepted.
    valid = 1'b1;
    start_load(1'b1, 12'd10);
    for (int i = 0; i < 5; i++) begin
      data = DW'(16'h0600 + i);
      tick();
    end
    check("t6_pre_b_addr", b_addr, 4);
    data = DW'(16'h0605);
    rst  = 1'b1;
    tick();
    rst   = 1'b0;
    valid = 1'b0;
    check("t6_rst_ready",  ready,  0);
    check("t6_rst_busy",   busy,   0);
    check("t6_rst_done",   done,   0);
    check("t6_rst_b_we",   b_we,   0);
    check("t6_rst_a_we",   a_we,   0);
    check("t6_rst_b_addr", b_addr, 0);
    check("t6_rst_a_addr", a_addr, 0);
    check("t6_rst_wdata",  wdata,  0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_done", done, 0);
      check("t6_no_we",   b_we, 0);
    end
    valid = 1'b1;
    data  = DW'(16'h0700);
    start_load(1'b1, 12'd2);
    tick();
    check("t6_new_we",   b_we,   1);
    check("t6_new_addr", b_addr, 0);
    check("t6_new_data", wdata,  DW'(16'h0700));
    data = DW'(16'h0701);
    tick();
    check("t6_new_addr1", b_addr, 1);
    check("t6_new_done",  done,   1);
    valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
